// File: rtl/matrix_stream_bank.sv
// Operand memory with a strided multi-lane burst engine and valid/ready output.
// Optional RD_WR_FWD_EN: same-edge write data is forwarded into fetched lanes.
`timescale 1ns/1ps
module matrix_stream_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      write_en,
    input  logic [DATA_W-1:0]         data,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    input  logic [CNT_W-1:0]          count,
    input  logic                      ready,
    output logic                      busy,
    output logic                      valid,
    output logic [LANES*DATA_W-1:0]   q,
    output logic                      last,
    output logic                      done
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, next_state;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]        ptr, stride_r, lane_addr;
    logic [CNT_W-1:0]         remaining;
    logic                     zero_done, fetch, load, zero_start;
    logic [LANES*DATA_W-1:0]  beat;

    always_ff @(posedge clk) begin
        if (write_en)
            mem[address] <= data;
    end

    always_comb begin
        beat      = '0;
        lane_addr = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_addr = ptr + ADDR_W'(i);
            beat[i*DATA_W +: DATA_W] = mem[lane_addr];
`ifdef RD_WR_FWD_EN
            if (write_en && address == lane_addr)
                beat[i*DATA_W +: DATA_W] = data;
`endif
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        zero_start = 1'b0;
        fetch      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        load       = 1'b1;
                        next_state = RUN;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            RUN: begin
                fetch = !valid || ready;
                if (fetch && remaining == CNT_W'(1))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Output slot: fetch refills it; a transfer without refill empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            stride_r  <= '0;
            remaining <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            q         <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= zero_start;
            if (load) begin
                ptr       <= base_addr;
                stride_r  <= stride;
                remaining <= count;
            end
            if (fetch) begin
                ptr       <= ptr + stride_r;
                remaining <= remaining - CNT_W'(1);
                valid     <= 1'b1;
                last      <= (remaining == CNT_W'(1));
                q         <= beat;
            end else if (valid && ready) begin
                valid <= 1'b0;
                last  <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = zero_done | (valid & last & ready);

endmodule

// File: tb/tb_matrix_stream_bank.sv
// Self-checking bench for matrix_stream_bank; expected beats come from a word-array model.
`timescale 1ns/1ps
module tb_matrix_stream_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic        write_en;
    logic [15:0] data;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  stride;
    logic [7:0]  count;
    logic        ready;
    logic        busy, valid, last, done;
    logic [63:0] q;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [256];

    logic [63:0] got_q [$];
    bit          got_last [$];
    bit          got_done [$];
    int          n_dones, hold_viol, first_valid_cyc;
    logic        busy_at1, busy_at_last;
    bit          timed_out;

    matrix_stream_bank #(.DATA_W(16), .ADDR_W(8), .LANES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .address(address), .write_en(write_en), .data(data),
        .start(start), .base_addr(base_addr), .stride(stride), .count(count),
        .ready(ready), .busy(busy), .valid(valid), .q(q), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_beat(input logic [7:0] b, input logic [7:0] s, input int k);
        logic [63:0] r;
        for (int i = 0; i < 4; i++)
            r[i*16 +: 16] = ref_mem[(int'(b) + int'(s) * k + i) % 256];
        return r;
    endfunction

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        write_en = 1'b1;
        address  = a;
        data     = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 write_en = 1'b0;
    endtask

    // Drives one burst and records every transferred beat.
    task automatic run_burst(input logic [7:0] b, input logic [7:0] s, input logic [7:0] c,
                             input int mode, input int inj_cyc, input logic [7:0] inj_a,
                             input logic [15:0] inj_d, input int restart_cyc);
        int          hold = 0;
        logic        pv = 1'b0, pr = 1'b0;
        logic [63:0] pq = '0;
        bit          finished = 1'b0;
        got_q.delete(); got_last.delete(); got_done.delete();
        n_dones = 0; hold_viol = 0; first_valid_cyc = -1; timed_out = 1'b0;
        busy_at1 = 1'b0; busy_at_last = 1'b1;
        for (int cyc = 0; cyc < int'(c) * 20 + 20; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (cyc == restart_cyc);
            base_addr = (cyc == 0) ? b : 8'($urandom);
            stride    = (cyc == 0) ? s : 8'($urandom);
            count     = (cyc == 0) ? c : 8'($urandom_range(1, 9));
            write_en  = (cyc == inj_cyc);
            address   = inj_a;
            data      = inj_d;
            case (mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: begin
                    ready = !(valid && hold < 3);
                    if (valid && !ready) hold++;
                end
            endcase
            #1;
            if (cyc == 1) busy_at1 = busy;
            if (pv && !pr && (!valid || q !== pq)) hold_viol++;
            if (done) n_dones++;
            if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid && ready) begin
                got_q.push_back(q);
                got_last.push_back(last);
                got_done.push_back(done);
                busy_at_last = busy;
            end
            pv = valid; pr = ready; pq = q;
            if (got_q.size() == int'(c)) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0; write_en = 1'b0; ready = 1'b1;
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic check_beats(input string name, input logic [7:0] b, input logic [7:0] s, input int c);
        checks++;
        if (timed_out || got_q.size() != c) begin
            failures++;
            $display("FAIL %s_count got=%0d expected=%0d timeout=%0d", name, got_q.size(), c, timed_out);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== model_beat(b, s, k)) begin
                failures++;
                $display("FAIL %s_beat%0d got=%h expected=%h", name, k, got_q[k], model_beat(b, s, k));
            end
            checks++;
            if (got_last[k] !== (k == c - 1) || got_done[k] !== (k == c - 1)) begin
                failures++;
                $display("FAIL %s_lastdone%0d got=%0d/%0d expected=%0d", name, k, got_last[k], got_done[k], k == c - 1);
            end
        end
        checks++;
        if (n_dones != 1 || hold_viol != 0) begin
            failures++;
            $display("FAIL %s_dones_hold got=%0d/%0d expected=1/0", name, n_dones, hold_viol);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; write_en = 1'b0; ready = 1'b1;
        address = '0; data = '0; base_addr = '0; stride = '0; count = '0;
        #1;
        checks++;
        if ({busy, valid, last, done} !== 4'b0 || q !== '0) begin
            failures++;
            $display("FAIL reset_values got=%b q=%h expected=0000 q=0", {busy, valid, last, done}, q);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        start = 1'b1; base_addr = 8'd16; stride = 8'd4; count = 8'd8; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL midburst_pre got=busy%0d valid%0d expected=busy1 valid1", busy, valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, last, done} !== 4'b0 || q !== '0) begin
            failures++;
            $display("FAIL midburst_rst got=%b q=%h expected=0000 q=0", {busy, valid, last, done}, q);
        end
        @(negedge clk);
        rst = 1'b0;
        run_burst(8'd40, 8'd3, 8'd3, 0, -1, '0, '0, -1);
        check_beats("after_reset", 8'd40, 8'd3, 3);
    endtask

    task automatic test_linear();
        logic [63:0] beat0_exp;
        beat0_exp = {16'd3, 16'd2, 16'd1, 16'd0};
        run_burst(8'd0, 8'd4, 8'd3, 0, -1, '0, '0, -1);
        check_beats("linear", 8'd0, 8'd4, 3);
        checks++;
        if (got_q.size() < 1 || got_q[0] !== beat0_exp) begin
            failures++;
            $display("FAIL linear_literal got=%h expected=%h", got_q.size() ? got_q[0] : 64'h0, beat0_exp);
        end
        checks++;
        if (first_valid_cyc != 2 || busy_at1 !== 1'b1 || busy_at_last !== 1'b0) begin
            failures++;
            $display("FAIL linear_timing got=%0d/%0d/%0d expected=2/1/0", first_valid_cyc, busy_at1, busy_at_last);
        end
    endtask

    task automatic test_backpressure();
        run_burst(8'd0, 8'd4, 8'd3, 2, -1, '0, '0, -1);
        check_beats("backpressure", 8'd0, 8'd4, 3);
    endtask

    task automatic test_wrap();
        run_burst(8'd254, 8'd1, 8'd2, 0, -1, '0, '0, -1);
        check_beats("wrap", 8'd254, 8'd1, 2);
    endtask

    task automatic test_forward();
        logic [15:0] exp;
        write_word(8'd5, 16'd1);
`ifdef RD_WR_FWD_EN
        exp = 16'h00AA;
`else
        exp = 16'd1;
`endif
        run_burst(8'd4, 8'd1, 8'd1, 0, 1, 8'd5, 16'h00AA, -1);
        checks++;
        if (got_q.size() != 1 || got_q[0][31:16] !== exp || got_q[0][15:0] !== ref_mem[4]) begin
            failures++;
            $display("FAIL forward got=%h expected_lane1=%h", got_q.size() ? got_q[0] : 64'h0, exp);
        end
        ref_mem[5] = 16'h00AA;
`ifdef RD_WR_FWD_EN
        exp = 16'h0BB0;
`else
        exp = ref_mem[0];
`endif
        run_burst(8'd254, 8'd1, 8'd1, 0, 1, 8'd0, 16'h0BB0, -1);
        checks++;
        if (got_q.size() != 1 || got_q[0][47:32] !== exp || got_q[0][15:0] !== ref_mem[254]) begin
            failures++;
            $display("FAIL forward_wrap got=%h expected_lane2=%h", got_q.size() ? got_q[0] : 64'h0, exp);
        end
        ref_mem[0] = 16'h0BB0;
    endtask

    task automatic test_zero_count();
        int dcnt = 0, vcnt = 0;
        @(negedge clk);
        start = 1'b1; count = 8'd0; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got=done%0d busy%0d expected=done1 busy0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done) dcnt++;
            if (valid) vcnt++;
        end
        checks++;
        if (dcnt != 0 || vcnt != 0) begin
            failures++;
            $display("FAIL zero_after got=done%0d valid%0d expected=0/0", dcnt, vcnt);
        end
    endtask

    task automatic test_start_busy();
        int extra = 0;
        run_burst(8'd0, 8'd4, 8'd3, 0, -1, '0, '0, 2);
        check_beats("start_busy", 8'd0, 8'd4, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (busy || valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL start_busy_ignored got=%0d expected=0", extra);
        end
    endtask

    task automatic test_random();
        logic [7:0] b, s, c;
        for (int n = 0; n < 6; n++) begin
            for (int w = 0; w < 8; w++)
                write_word(8'($urandom), 16'($urandom));
            b = 8'($urandom);
            s = 8'($urandom);
            c = 8'($urandom_range(1, 10));
            run_burst(b, s, c, 1, -1, '0, '0, -1);
            check_beats("random", b, s, int'(c));
        end
    endtask

    task automatic test_back_to_back();
        run_burst(8'd100, 8'd8, 8'd4, 0, -1, '0, '0, -1);
        check_beats("b2b_first", 8'd100, 8'd8, 4);
        run_burst(8'd250, 8'd7, 8'd5, 0, -1, '0, '0, -1);
        check_beats("b2b_second", 8'd250, 8'd7, 5);
    endtask

    initial begin
        test_reset();
        for (int n = 0; n < 256; n++)
            write_word(8'(n), 16'(n));
        test_linear();
        test_backpressure();
        test_reset_mid_burst();
        test_wrap();
        test_forward();
        test_zero_count();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
